hdmi_video_timing_gen: RTL and testbench

- Parametrised video timing and framebuffer-address generator for the HDMI transmit path, running in the pixel clock domain (clk_low).
- Produces hsync, vsync and data-enable with configurable sync polarity, plus a read address for the frame buffer.
- The read address is issued RD_LAT cycles ahead of the matching data-enable, so memory read latency is absorbed.
- Adds start/stop at frame boundaries, integer pixel/line replication (upscaling), a configurable line stride and pixel-underflow detection; its outputs feed the TMDS encoders.

---
 rtl/hdmi_video_timing_gen_if.sv | 33 +++
 rtl/hdmi_video_timing_gen.sv | 206 ++++++++++++++++++++
 tb/tb_hdmi_video_timing_gen.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_video_timing_gen_if.sv
// Control/status bundle between the HDMI video timing generator and its host/frame-buffer side.
// The host side drives run control and frame-buffer status; the generator drives timing and address.
interface hdmi_video_timing_gen_if #(
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned ADDR_W = 21
);
  logic              enable;
  logic [ADDR_W-1:0] addr_base;
  logic              pix_valid;
  logic              underflow_clr;

  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic [CNT_W-1:0]  x;
  logic [CNT_W-1:0]  y;
  logic              sof;
  logic              eol;
  logic [15:0]       frame_cnt;
  logic              underflow;

  modport master (
    output enable, addr_base, pix_valid, underflow_clr,
    input  addr, addr_valid, hsync, vsync, de, x, y, sof, eol, frame_cnt, underflow
  );

  modport slave (
    input  enable, addr_base, pix_valid, underflow_clr,
    output addr, addr_valid, hsync, vsync, de, x, y, sof, eol, frame_cnt, underflow
  );
endinterface

// File: rtl/hdmi_video_timing_gen.sv
// Pixel-clock video timing and frame-buffer address generator for the HDMI TX path.
// Read addresses lead the matching data-enable by RD_LAT cycles to absorb memory latency.
module hdmi_video_timing_gen #(
  parameter int unsigned H_PIXEL       = 640,
  parameter int unsigned H_FRONT_PORCH = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_TOT_PIXEL   = 800,
  parameter int unsigned V_PIXEL       = 480,
  parameter int unsigned V_FRONT_PORCH = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_TOT_PIXEL   = 525,
  parameter bit          H_SYNC_POL    = 1'b0,
  parameter bit          V_SYNC_POL    = 1'b0,
  parameter int unsigned CNT_W         = 12,
  parameter int unsigned ADDR_W        = 21,
  parameter int unsigned LINE_STRIDE   = 640,
  parameter int unsigned SCALE_SHIFT_X = 0,
  parameter int unsigned SCALE_SHIFT_Y = 0,
  parameter int unsigned RD_LAT        = 1
) (
  input  logic                   clk_low,
  input  logic                   reset,
  hdmi_video_timing_gen_if.slave vid
);

  localparam logic [CNT_W-1:0]  H_LAST     = CNT_W'(H_TOT_PIXEL - 1);
  localparam logic [CNT_W-1:0]  V_LAST     = CNT_W'(V_TOT_PIXEL - 1);
  localparam logic [CNT_W-1:0]  H_ACT      = CNT_W'(H_PIXEL);
  localparam logic [CNT_W-1:0]  V_ACT      = CNT_W'(V_PIXEL);
  localparam logic [CNT_W-1:0]  H_ACT_LAST = CNT_W'(H_PIXEL - 1);
  localparam logic [CNT_W-1:0]  HS_START   = CNT_W'(H_PIXEL + H_FRONT_PORCH);
  localparam logic [CNT_W-1:0]  HS_END     = CNT_W'(H_PIXEL + H_FRONT_PORCH + H_SYNC);
  localparam logic [CNT_W-1:0]  VS_START   = CNT_W'(V_PIXEL + V_FRONT_PORCH);
  localparam logic [CNT_W-1:0]  VS_END     = CNT_W'(V_PIXEL + V_FRONT_PORCH + V_SYNC);
  localparam logic [CNT_W-1:0]  Y_REP_MASK = CNT_W'((1 << SCALE_SHIFT_Y) - 1);
  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(LINE_STRIDE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // One pipeline slot; hs/vs carry the physical line level (polarity already applied).
  typedef struct packed {
    logic             act;
    logic             hs;
    logic             vs;
    logic             sof;
    logic             eol;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{
    act: 1'b0, hs: !H_SYNC_POL, vs: !V_SYNC_POL, sof: 1'b0, eol: 1'b0, x: '0, y: '0
  };

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  h_q, h_d;
  logic [CNT_W-1:0]  v_q, v_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_valid_q, addr_valid_d;
  stage_t            stage_q [0:RD_LAT];
  stage_t            stage0_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              underflow_q, underflow_d;

  logic running;
  logic h_wrap;
  logic v_wrap;
  logic frame_end;
  logic act_c;
  logic hs_on;
  logic vs_on;

  assign running   = (state_q != ST_IDLE);
  assign h_wrap    = (h_q == H_LAST);
  assign v_wrap    = (v_q == V_LAST);
  assign frame_end = h_wrap && v_wrap;
  assign act_c     = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_on     = (h_q >= HS_START) && (h_q < HS_END);
  assign vs_on     = (v_q >= VS_START) && (v_q < VS_END);

  // Run control, raster counters and per-line frame-buffer base.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    line_base_d = line_base_q;

    unique case (state_q)
      ST_IDLE: begin
        if (vid.enable) begin
          state_d     = ST_RUN;
          line_base_d = vid.addr_base;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (vid.enable) begin
          state_d = ST_RUN;
        end else if ((state_q == ST_DRAIN) && frame_end) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end

        if (h_wrap) begin
          h_d = '0;
          v_d = v_wrap ? '0 : v_q + CNT_W'(1);
        end else begin
          h_d = h_q + CNT_W'(1);
        end

        // Advance to the next source line once every replicated copy has been shown.
        if (act_c && (h_q == H_ACT_LAST) && ((v_q & Y_REP_MASK) == Y_REP_MASK)) begin
          line_base_d = line_base_q + STRIDE;
        end
        if (frame_end && (state_d != ST_IDLE)) begin
          line_base_d = vid.addr_base;
        end
      end
      default: begin
        state_d = ST_IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk_low or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      h_q         <= '0;
      v_q         <= '0;
      line_base_q <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      line_base_q <= line_base_d;
    end
  end

  // Stage 0 decode, address, frame counter and underflow next-state.
  always_comb begin
    stage0_d     = STAGE_IDLE;
    addr_d       = addr_q;
    addr_valid_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    if (running) begin
      stage0_d.act = act_c;
      stage0_d.hs  = hs_on ~^ H_SYNC_POL;
      stage0_d.vs  = vs_on ~^ V_SYNC_POL;
      stage0_d.sof = (h_q == '0) && (v_q == '0);
      stage0_d.eol = (h_q == H_ACT_LAST) && (v_q < V_ACT);
      stage0_d.x   = h_q;
      stage0_d.y   = v_q;
      addr_d       = line_base_q + ADDR_W'(h_q >> SCALE_SHIFT_X);
      addr_valid_d = act_c;
    end

    // Counts together with the sof output so both change on the same edge.
    if (stage_q[RD_LAT-1].sof) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    underflow_d = (stage_q[RD_LAT].act && !vid.pix_valid) || (underflow_q && !vid.underflow_clr);
  end

  always_ff @(posedge clk_low or negedge reset) begin
    if (!reset) begin
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      frame_cnt_q  <= '0;
      underflow_q  <= 1'b0;
      for (int i = 0; i <= int'(RD_LAT); i++) begin
        stage_q[i] <= STAGE_IDLE;
      end
    end else begin
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      frame_cnt_q  <= frame_cnt_d;
      underflow_q  <= underflow_d;
      stage_q[0]   <= stage0_d;
      for (int i = 1; i <= int'(RD_LAT); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign vid.addr       = addr_q;
  assign vid.addr_valid = addr_valid_q;
  assign vid.hsync      = stage_q[RD_LAT].hs;
  assign vid.vsync      = stage_q[RD_LAT].vs;
  assign vid.de         = stage_q[RD_LAT].act;
  assign vid.x          = stage_q[RD_LAT].x;
  assign vid.y          = stage_q[RD_LAT].y;
  assign vid.sof        = stage_q[RD_LAT].sof;
  assign vid.eol        = stage_q[RD_LAT].eol;
  assign vid.frame_cnt  = frame_cnt_q;
  assign vid.underflow  = underflow_q;

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Scoreboard bench for hdmi_video_timing_gen: two instances (active-low sync/no scaling and
// active-high sync/2x scaling) share random stimulus and are checked against a raster-position model.
module tb_hdmi_video_timing_gen;

  localparam int HP  = 8;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HT  = 16;
  localparam int VP  = 4;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VT  = 8;
  localparam int RL  = 2;
  localparam int CW  = 12;
  localparam int AW  = 21;
  localparam int FT  = HT * VT;

  logic          clk           = 1'b0;
  logic          rst_n         = 1'b0;
  logic          enable        = 1'b0;
  logic [AW-1:0] addr_base     = 21'h100;
  logic          pix_valid     = 1'b1;
  logic          underflow_clr = 1'b0;
  bit            force_uf      = 1'b0;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int inst, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s at cycle %0d: got 0x%0h, expected 0x%0h", inst, name, cyc, act, exp);
    end
  endtask

  typedef struct { int stamp; logic [AW-1:0] addr; } addr_exp_t;
  typedef struct { int stamp; int x; int y; bit sof; bit eol; } pix_exp_t;
  typedef struct { int stamp; bit hs; bit vs; } sync_exp_t;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam bit POL    = (gi == 1);
    localparam int SX     = gi;
    localparam int SY     = gi;
    localparam int STRIDE = (gi == 0) ? 8 : 12;

    hdmi_video_timing_gen_if #(.CNT_W(CW), .ADDR_W(AW)) vid ();

    assign vid.enable        = enable;
    assign vid.addr_base     = addr_base;
    assign vid.pix_valid     = pix_valid;
    assign vid.underflow_clr = underflow_clr;

    hdmi_video_timing_gen #(
      .H_PIXEL(HP), .H_FRONT_PORCH(HFP), .H_SYNC(HSW), .H_TOT_PIXEL(HT),
      .V_PIXEL(VP), .V_FRONT_PORCH(VFP), .V_SYNC(VSW), .V_TOT_PIXEL(VT),
      .H_SYNC_POL(POL), .V_SYNC_POL(POL), .CNT_W(CW), .ADDR_W(AW),
      .LINE_STRIDE(STRIDE), .SCALE_SHIFT_X(SX), .SCALE_SHIFT_Y(SY), .RD_LAT(RL)
    ) dut (
      .clk_low (clk),
      .reset   (rst_n),
      .vid     (vid)
    );

    addr_exp_t     addr_q[$];
    pix_exp_t      pix_q[$];
    sync_exp_t     sync_q[$];
    bit            run_m   = 1'b0;
    bit            en_prev = 1'b0;
    int            pos     = 0;
    logic [AW-1:0] fbase   = '0;
    bit            uf_exp  = 1'b0;
    int            fc_exp  = 0;

    // Reference: raster position within the frame; stops only at a frame end after enable was low twice.
    always @(posedge clk) begin : model
      int  k, h, v;
      bit  act, hs_on, vs_on;
      k = cyc + 1;
      if (!rst_n) begin
        run_m = 1'b0;
        pos   = 0;
      end else begin
        if (!run_m) begin
          if (enable) begin
            run_m   = 1'b1;
            pos     = 0;
            fbase   = addr_base;
            en_prev = 1'b1;
          end
        end else begin
          if (pos == FT - 1 && !enable && !en_prev) begin
            run_m = 1'b0;
            pos   = 0;
          end else begin
            pos = (pos + 1) % FT;
            if (pos == 0) fbase = addr_base;
          end
          en_prev = enable;
        end
        if (run_m) begin
          h     = pos % HT;
          v     = pos / HT;
          act   = (h < HP) && (v < VP);
          hs_on = (h >= HP + HFP) && (h < HP + HFP + HSW);
          vs_on = (v >= VP + VFP) && (v < VP + VFP + VSW);
          sync_q.push_back('{k + 1 + RL, POL ? hs_on : !hs_on, POL ? vs_on : !vs_on});
          if (act) begin
            addr_q.push_back('{k + 1, AW'(32'(fbase) + 32'((v >> SY) * STRIDE) + 32'(h >> SX))});
            pix_q.push_back('{k + 1 + RL, h, v, (h == 0 && v == 0), (h == HP - 1)});
          end
        end
      end
    end

    always @(negedge clk) begin : monitor
      bit        exp_hs, exp_vs, exp_de, exp_av;
      pix_exp_t  p;
      addr_exp_t a;
      if (!rst_n) begin
        addr_q.delete();
        pix_q.delete();
        sync_q.delete();
        uf_exp = 1'b0;
        fc_exp = 0;
        chk(gi, "rst_addr", 32'(vid.addr), 32'd0);
        chk(gi, "rst_addr_valid", 32'(vid.addr_valid), 32'd0);
        chk(gi, "rst_de", 32'(vid.de), 32'd0);
        chk(gi, "rst_sof", 32'(vid.sof), 32'd0);
        chk(gi, "rst_eol", 32'(vid.eol), 32'd0);
        chk(gi, "rst_x", 32'(vid.x), 32'd0);
        chk(gi, "rst_y", 32'(vid.y), 32'd0);
        chk(gi, "rst_frame_cnt", 32'(vid.frame_cnt), 32'd0);
        chk(gi, "rst_underflow", 32'(vid.underflow), 32'd0);
        chk(gi, "rst_hsync", 32'(vid.hsync), 32'(!POL));
        chk(gi, "rst_vsync", 32'(vid.vsync), 32'(!POL));
      end else begin
        exp_hs = !POL;
        exp_vs = !POL;
        if (sync_q.size() > 0 && sync_q[0].stamp == cyc) begin
          exp_hs = sync_q[0].hs;
          exp_vs = sync_q[0].vs;
          void'(sync_q.pop_front());
        end
        chk(gi, "hsync", 32'(vid.hsync), 32'(exp_hs));
        chk(gi, "vsync", 32'(vid.vsync), 32'(exp_vs));

        exp_de = (pix_q.size() > 0 && pix_q[0].stamp == cyc);
        chk(gi, "de", 32'(vid.de), 32'(exp_de));
        if (exp_de) begin
          p = pix_q.pop_front();
          chk(gi, "x", 32'(vid.x), 32'(p.x));
          chk(gi, "y", 32'(vid.y), 32'(p.y));
          chk(gi, "sof", 32'(vid.sof), 32'(p.sof));
          chk(gi, "eol", 32'(vid.eol), 32'(p.eol));
          if (p.sof) fc_exp = (fc_exp + 1) % 65536;
        end else begin
          chk(gi, "sof_blank", 32'(vid.sof), 32'd0);
          chk(gi, "eol_blank", 32'(vid.eol), 32'd0);
        end
        chk(gi, "frame_cnt", 32'(vid.frame_cnt), 32'(fc_exp));

        exp_av = (addr_q.size() > 0 && addr_q[0].stamp == cyc);
        chk(gi, "addr_valid", 32'(vid.addr_valid), 32'(exp_av));
        if (exp_av) begin
          a = addr_q.pop_front();
          chk(gi, "addr", 32'(vid.addr), 32'(a.addr));
        end

        chk(gi, "underflow", 32'(vid.underflow), 32'(uf_exp));
        uf_exp = (exp_de && !pix_valid) || (uf_exp && !underflow_clr);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (force_uf) begin
        pix_valid     = 1'b0;
        underflow_clr = 1'b1;
      end else begin
        pix_valid     = ($urandom_range(0, 39) != 0);
        underflow_clr = ($urandom_range(0, 29) == 0);
      end
    end
  endtask

  initial begin
    step(3);
    rst_n  = 1'b1;
    enable = 1'b1;
    step(2 * FT + 10);

    // Drop enable in line 1, re-raise during the drain, then let it stop.
    step(HT + 3);
    enable = 1'b0;
    step(3 * HT);
    enable = 1'b1;
    step(2 * FT);
    enable = 1'b0;
    step(2 * FT + 20);

    // Underflow events coinciding with clears, then clears without events.
    enable = 1'b1;
    step(5);
    force_uf = 1'b1;
    step(FT);
    force_uf = 1'b0;
    step(FT);

    for (int i = 0; i < 14; i++) begin
      enable = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) addr_base = AW'($urandom);
      step(int'($urandom_range(5, 300)));
    end

    enable = 1'b0;
    step(2 * FT + 20);
    addr_base = 21'h1FFFF8;
    enable    = 1'b1;
    step(FT + 50);

    // Reset in the middle of a line, then restart.
    step(int'($urandom_range(1, HP - 2)));
    rst_n = 1'b0;
    step(2);
    addr_base = 21'h040;
    rst_n     = 1'b1;
    step(2 * FT + 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
